// File: rtl/pcs_rx_decoder_sm.sv
// PCS receive state machine: frames PAM5 symbol vectors into rxd/rx_dv/rx_er.
// Define PCS_RX_ERR_CNT_EN to add the saturating io_err_count output.
module pcs_rx_decoder_sm (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rx_symb_vector_valid,
    output logic       io_rx_symb_vector_ready,
    input  logic [2:0] io_rx_symb_vector_bits_0,
    input  logic [2:0] io_rx_symb_vector_bits_1,
    input  logic [2:0] io_rx_symb_vector_bits_2,
    input  logic [2:0] io_rx_symb_vector_bits_3,
    input  logic [7:0] io_decoded_rx_symb_vector,
    input  logic       io_loc_rcvr_status,
    input  logic       io_pcs_reset,
    output logic [7:0] io_rxd,
    output logic       io_rx_dv,
    output logic       io_rx_er,
    output logic       io_rxerror_status
`ifdef PCS_RX_ERR_CNT_EN
    ,
    output logic [7:0] io_err_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_SSD1_SEEN, S_DATA, S_ESD1_SEEN, S_FALSE_CARRIER
    } state_t;

    localparam logic signed [2:0] SYM_P2 = 3'sd2;
    localparam logic signed [2:0] SYM_M2 = -3'sd2;
    localparam logic [7:0] RXD_FC  = 8'h0E;
    localparam logic [7:0] RXD_SFD = 8'h55;

    function automatic logic sym_legal(input logic signed [2:0] s);
        return (s >= SYM_M2) && (s <= SYM_P2);
    endfunction

    function automatic logic sym_idle(input logic signed [2:0] s);
        return (s == SYM_M2) || (s == 3'sd0) || (s == SYM_P2);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q, state_nxt;
    logic signed [2:0] sym [4];
    logic             accept, any_illegal, all_idle, is_d1, is_d2;
    logic [7:0]       rxd_nxt, cnt_q, cnt_nxt;
    logic             dv_nxt, er_nxt, sts_nxt;

    assign sym[0] = io_rx_symb_vector_bits_0;
    assign sym[1] = io_rx_symb_vector_bits_1;
    assign sym[2] = io_rx_symb_vector_bits_2;
    assign sym[3] = io_rx_symb_vector_bits_3;

    assign io_rx_symb_vector_ready = ~reset;
    assign accept = io_rx_symb_vector_valid & io_rx_symb_vector_ready;

    always_comb begin
        any_illegal = 1'b0;
        all_idle    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            any_illegal = any_illegal | ~sym_legal(sym[i]);
            all_idle    = all_idle & sym_idle(sym[i]);
        end
        is_d1 = (sym[0] == SYM_P2) && (sym[1] == SYM_P2) && (sym[2] == SYM_P2) && (sym[3] == SYM_P2);
        is_d2 = (sym[0] == SYM_P2) && (sym[1] == SYM_P2) && (sym[2] == SYM_P2) && (sym[3] == SYM_M2);
    end

    always_comb begin
        state_nxt = state_q;
        rxd_nxt   = io_rxd;
        dv_nxt    = io_rx_dv;
        er_nxt    = io_rx_er;
        sts_nxt   = io_rxerror_status;
        cnt_nxt   = cnt_q;
        if (io_pcs_reset) begin
            state_nxt = S_IDLE;
            rxd_nxt   = 8'h00;
            dv_nxt    = 1'b0;
            er_nxt    = 1'b0;
            sts_nxt   = 1'b0;
            cnt_nxt   = 8'h00;
        end else if (accept) begin
            rxd_nxt = 8'h00;
            dv_nxt  = 1'b0;
            er_nxt  = 1'b0;
            case (state_q)
                S_IDLE: begin
                    // SSD1 is itself an idle-class vector, so it must be tested first
                    if (is_d1) begin
                        state_nxt = S_SSD1_SEEN;
                    end else if (!all_idle) begin
                        state_nxt = S_FALSE_CARRIER;
                        er_nxt    = 1'b1;
                        rxd_nxt   = RXD_FC;
                    end
                end
                S_SSD1_SEEN: begin
                    if (is_d2) begin
                        state_nxt = S_DATA;
                        dv_nxt    = 1'b1;
                        rxd_nxt   = RXD_SFD;
                    end else begin
                        state_nxt = S_FALSE_CARRIER;
                        er_nxt    = 1'b1;
                        rxd_nxt   = RXD_FC;
                    end
                end
                S_DATA: begin
                    if (!io_loc_rcvr_status) begin
                        state_nxt = S_IDLE;
                        dv_nxt    = 1'b1;
                        er_nxt    = 1'b1;
                    end else if (is_d1) begin
                        state_nxt = S_ESD1_SEEN;
                    end else begin
                        dv_nxt  = 1'b1;
                        er_nxt  = any_illegal;
                        rxd_nxt = io_decoded_rx_symb_vector;
                    end
                end
                S_ESD1_SEEN: begin
                    // Link loss and a bad second delimiter both end as an error beat
                    state_nxt = S_IDLE;
                    if (!io_loc_rcvr_status || !is_d2) begin
                        dv_nxt = 1'b1;
                        er_nxt = 1'b1;
                    end
                end
                S_FALSE_CARRIER: begin
                    if (all_idle) begin
                        state_nxt = S_IDLE;
                    end else begin
                        er_nxt  = 1'b1;
                        rxd_nxt = RXD_FC;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            if (er_nxt) begin
                sts_nxt = 1'b1;
                cnt_nxt = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_rxd            <= 8'h00;
            io_rx_dv          <= 1'b0;
            io_rx_er          <= 1'b0;
            io_rxerror_status <= 1'b0;
            cnt_q             <= 8'h00;
        end else begin
            io_rxd            <= rxd_nxt;
            io_rx_dv          <= dv_nxt;
            io_rx_er          <= er_nxt;
            io_rxerror_status <= sts_nxt;
            cnt_q             <= cnt_nxt;
        end
    end

`ifdef PCS_RX_ERR_CNT_EN
    assign io_err_count = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_pcs_rx_decoder_sm.sv
// Scoreboard bench for pcs_rx_decoder_sm: driver pushes reference-model results,
// monitor pops them on each accepted beat / soft reset and checks held values otherwise.
module tb_pcs_rx_decoder_sm;

    localparam logic [2:0] P2 = 3'b010, P1 = 3'b001, Z = 3'b000, M1 = 3'b111, M2 = 3'b110;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic       ready;
    logic [2:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic [7:0] dbyte = '0;
    logic       loc = 1'b1;
    logic       pcs_reset = 1'b0;
    logic [7:0] rxd;
    logic       rx_dv, rx_er, sts;
`ifdef PCS_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    pcs_rx_decoder_sm dut (
        .clock(clock), .reset(reset),
        .io_rx_symb_vector_valid(valid), .io_rx_symb_vector_ready(ready),
        .io_rx_symb_vector_bits_0(s0), .io_rx_symb_vector_bits_1(s1),
        .io_rx_symb_vector_bits_2(s2), .io_rx_symb_vector_bits_3(s3),
        .io_decoded_rx_symb_vector(dbyte), .io_loc_rcvr_status(loc),
        .io_pcs_reset(pcs_reset), .io_rxd(rxd), .io_rx_dv(rx_dv), .io_rx_er(rx_er),
        .io_rxerror_status(sts)
`ifdef PCS_RX_ERR_CNT_EN
        , .io_err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] rxd;
        logic       dv, er, sts, chk_rxd;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t m;          // model's current output view
    int   mode;       // 0 idle, 1 after SSD1, 2 in frame, 3 after ESD1, 4 false carrier
    int   n_chk = 0, n_fail = 0;

    function automatic exp_t zero_exp();
        exp_t e;
        e.rxd = 8'h00; e.dv = 1'b0; e.er = 1'b0; e.sts = 1'b0; e.chk_rxd = 1'b1; e.cnt = 8'h00;
        return e;
    endfunction

    function automatic int sval(input logic [2:0] s);
        return s[2] ? int'(s) - 8 : int'(s);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_out(input logic dv, input logic er, input logic [7:0] r, input logic chk);
        m.dv = dv; m.er = er; m.rxd = r; m.chk_rxd = chk;
    endtask

    // Reference model: evaluates one accepted beat from the delimiter/legality rules.
    task automatic model_beat(input logic [2:0] a, b, c, d, input logic [7:0] db, input logic lk);
        int v[4];
        bit bad, idl, d1, d2;
        v[0] = sval(a); v[1] = sval(b); v[2] = sval(c); v[3] = sval(d);
        bad = 0; idl = 1;
        foreach (v[i]) begin
            if (v[i] < -2 || v[i] > 2) bad = 1;
            if (!(v[i] == -2 || v[i] == 0 || v[i] == 2)) idl = 0;
        end
        d1 = (v[0] == 2 && v[1] == 2 && v[2] == 2 && v[3] == 2);
        d2 = (v[0] == 2 && v[1] == 2 && v[2] == 2 && v[3] == -2);
        if ((mode == 2 || mode == 3) && !lk) begin
            set_out(1, 1, 8'h00, 1); mode = 0;
        end else begin
            case (mode)
                0: if (d1) begin set_out(0, 0, 8'h00, 0); mode = 1; end
                   else if (idl) set_out(0, 0, 8'h00, 1);
                   else begin set_out(0, 1, 8'h0E, 1); mode = 4; end
                1: if (d2) begin set_out(1, 0, 8'h55, 1); mode = 2; end
                   else begin set_out(0, 1, 8'h0E, 1); mode = 4; end
                2: if (d1) begin set_out(0, 0, 8'h00, 1); mode = 3; end
                   else set_out(1, bad, db, 1);
                3: begin
                    if (d2) set_out(0, 0, 8'h00, 0); else set_out(1, 1, 8'h00, 1);
                    mode = 0;
                end
                default: if (idl) begin set_out(0, 0, 8'h00, 0); mode = 0; end
                         else set_out(0, 1, 8'h0E, 1);
            endcase
        end
        if (m.er) begin
            m.sts = 1;
            if (m.cnt != 8'hFF) m.cnt = m.cnt + 1;
        end
    endtask

    task automatic beat(input logic [2:0] a, b, c, d, input logic [7:0] db, input logic lk);
        @(negedge clock);
        valid = 1; pcs_reset = 0;
        s0 = a; s1 = b; s2 = c; s3 = d; dbyte = db; loc = lk;
        model_beat(a, b, c, d, db, lk);
        q.push_back(m);
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clock);
            valid = 0; loc = 1'($urandom);
            s0 = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom); s3 = 3'($urandom);
            dbyte = 8'($urandom);
        end
    endtask

    task automatic soft_reset(input logic lk);
        @(negedge clock);
        valid = 1'($urandom); pcs_reset = 1; loc = lk;
        s0 = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom); s3 = 3'($urandom);
        m = zero_exp(); mode = 0;
        q.push_back(m);
        @(negedge clock);
        pcs_reset = 0; valid = 0; loc = 1;
    endtask

    task automatic hard_reset(input string tag);
        @(negedge clock);
        #2 reset = 1; valid = 1;
        #1;
        check({tag, "_rxd"}, rxd, 8'h00);
        check({tag, "_dv"}, {7'd0, rx_dv}, 8'h00);
        check({tag, "_er"}, {7'd0, rx_er}, 8'h00);
        check({tag, "_sts"}, {7'd0, sts}, 8'h00);
        check({tag, "_ready_low"}, {7'd0, ready}, 8'h00);
        m = zero_exp(); mode = 0;
        repeat (2) @(negedge clock);
        #2 reset = 0; valid = 0;
        #1 check({tag, "_ready_high"}, {7'd0, ready}, 8'h01);
    endtask

    function automatic logic [2:0] rleg();
        logic [2:0] t[5];
        t = '{M2, M1, Z, P1, P2};
        return t[$urandom_range(0, 4)];
    endfunction

    function automatic logic [2:0] ridle();
        logic [2:0] t[3];
        t = '{M2, Z, P2};
        return t[$urandom_range(0, 2)];
    endfunction

    task automatic rand_frame();
        int nd, r;
        nd = $urandom_range(1, 6);
        repeat ($urandom_range(0, 2)) beat(ridle(), ridle(), ridle(), M2, 8'($urandom), 1'($urandom_range(0, 4) != 0));
        beat(P2, P2, P2, P2, 8'($urandom), 1);
        if ($urandom_range(0, 9) == 0) beat(rleg(), rleg(), rleg(), rleg(), 8'($urandom), 1);
        else beat(P2, P2, P2, M2, 8'($urandom), 1);
        for (int i = 0; i < nd; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) beat(3'($urandom_range(3, 5)), rleg(), rleg(), rleg(), 8'($urandom), 1);
            else if (r < 15) beat(rleg(), rleg(), rleg(), rleg(), 8'($urandom), 0);
            else if (r < 20) beat(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1);
            else beat(rleg(), rleg(), rleg(), M1, 8'($urandom), 1);
        end
        beat(P2, P2, P2, P2, 8'($urandom), 1'($urandom_range(0, 19) != 0));
        if ($urandom_range(0, 9) == 0) beat(rleg(), rleg(), rleg(), rleg(), 8'($urandom), 1);
        else beat(P2, P2, P2, M2, 8'($urandom), 1);
        if ($urandom_range(0, 29) == 0) soft_reset(1'($urandom));
    endtask

    // Monitor: pop on accepted beats and soft resets, otherwise outputs must hold.
    initial begin
        exp_t cur;
        logic acc, pr, rs;
        cur = zero_exp();
        forever begin
            @(posedge clock);
            acc = valid && ready; pr = pcs_reset; rs = reset;
            #1;
            if (rs || reset) begin
                cur = zero_exp();
                continue;
            end
            if (acc || pr) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_beat got beat want none at %0t", $time);
                end else begin
                    cur = q.pop_front();
                end
            end
            check("rx_dv", {7'd0, rx_dv}, {7'd0, cur.dv});
            check("rx_er", {7'd0, rx_er}, {7'd0, cur.er});
            check("rxerror_status", {7'd0, sts}, {7'd0, cur.sts});
            if (cur.chk_rxd) check("rxd", rxd, cur.rxd);
`ifdef PCS_RX_ERR_CNT_EN
            check("err_count", err_count, cur.cnt);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        m = zero_exp(); mode = 0;
        #3 reset = 1;
        #1;
        check("init_rxd", rxd, 8'h00);
        check("init_dv", {7'd0, rx_dv}, 8'h00);
        check("init_ready_low", {7'd0, ready}, 8'h00);
        repeat (2) @(negedge clock);
        #2 reset = 0;
        #1 check("init_ready_high", {7'd0, ready}, 8'h01);

        // normal frame
        beat(Z, M2, P2, Z, 8'h00, 1); beat(M2, M2, Z, P2, 8'h00, 1);
        beat(P2, P2, P2, P2, 8'h00, 1); beat(P2, P2, P2, M2, 8'h00, 1);
        beat(P1, Z, M1, Z, 8'hAA, 1); beat(M1, P1, Z, P2, 8'hF0, 1);
        beat(Z, Z, P1, M2, 8'h0F, 1); beat(P2, M1, M1, P1, 8'hCC, 1);
        beat(P2, P2, P2, P2, 8'h00, 1); beat(P2, P2, P2, M2, 8'h00, 1);
        // back-to-back frame with symbol error, then premature end
        beat(P2, P2, P2, P2, 8'h00, 1); beat(P2, P2, P2, M2, 8'h00, 1);
        beat(3'b100, Z, P1, Z, 8'h12, 1); beat(Z, P1, Z, M1, 8'h34, 1);
        beat(P2, P2, P2, P2, 8'h00, 1); beat(Z, Z, Z, Z, 8'h00, 1);
        // false carrier
        beat(P1, Z, Z, Z, 8'h00, 1); beat(Z, Z, Z, Z, 8'h00, 1);
        soft_reset(1);
        // link loss in frame, then a fresh frame proves return to idle
        beat(P2, P2, P2, P2, 8'h00, 1); beat(P2, P2, P2, M2, 8'h00, 1);
        beat(P1, P1, Z, Z, 8'h5A, 1); beat(P1, P1, Z, Z, 8'h77, 0);
        beat(Z, Z, Z, Z, 8'h00, 1);
        beat(P2, P2, P2, P2, 8'h00, 1); beat(P2, P2, P2, M2, 8'h00, 1);
        beat(M1, Z, Z, Z, 8'h99, 1);
        // soft reset coinciding with link loss in frame
        soft_reset(0);
        beat(Z, Z, Z, Z, 8'h00, 1);
        // asynchronous reset mid-frame
        beat(P2, P2, P2, P2, 8'h00, 1); beat(P2, P2, P2, M2, 8'h00, 1);
        beat(P1, Z, Z, Z, 8'h3C, 1);
        hard_reset("midframe");
        repeat (2) @(negedge clock);
        // long false-carrier run saturates the error count
        for (int i = 0; i < 301; i++) beat(P1, Z, Z, Z, 8'h00, 1);
        soft_reset(1);
        beat(Z, Z, Z, Z, 8'h00, 1);
        // randomized traffic
        for (int i = 0; i < 150; i++) rand_frame();

        repeat (4) @(negedge clock);
        check("queue_drained", 8'(q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
